// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_pkg (package)
// Description : Shared types and helpers for the sorting networks and the
//               streaming merger: element type, merger state encoding and
//               the element compare function.
// Revision    : 1.0 - initial release
// ============================================================================
package sort_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [1:0] {
    MERGE   = 2'd0,
    DRAIN_A = 2'd1,
    DRAIN_B = 2'd2
  } merge_state_t;

  // a <= b under the selected ordering. Returning true on equality is what
  // keeps merges and compare-swaps stable (the 'a' side wins ties).
  function automatic logic le(input data_t a, input data_t b, input logic unsigned_cmp);
    if (unsigned_cmp) begin
      return a <= b;
    end else begin
      return $signed(a) <= $signed(b);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : stream_out_reg
// Description : One-entry registered output stage of a valid/ready stream.
//               Loads a new beat whenever the stage is empty or the current
//               beat is being taken downstream; otherwise holds.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push          - a beat is presented for loading this cycle
//               i_data, i_last  - beat payload
//               i_out_ready     - downstream accepts the current beat
//               o_load          - stage can take a beat this cycle
//               o_valid, o_data, o_last - registered output beat
// Revision    : 1.0 - initial release
// ============================================================================
module stream_out_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_out_ready,
  output logic              o_load,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;

  assign o_load = !r_valid || i_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
    end else if (o_load) begin
      r_valid <= i_push;
      // Payload only moves on a real beat; an empty stage keeps stale data.
      if (i_push) begin
        r_data <= i_data;
        r_last <= i_last;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/merge_stream_2.sv
`default_nettype none
// ============================================================================
// Module      : merge_stream_2
// Description : Two-way streaming merger. Combines two ascending runs (A, B)
//               into one ascending run, one element per cycle, registered
//               output. Ties go to stream A.
// Ports       : clk, rst                       - clock, sync active-high reset
//               a_valid/a_ready/a_data/a_last  - input stream A
//               b_valid/b_ready/b_data/b_last  - input stream B
//               out_valid/out_ready/out_data/out_last - merged stream
//               order_err                      - sticky ordering error
// Options     : MERGE_STREAM_ORDER_CHECK_EN - builds the output order checker;
//               without it order_err is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module merge_stream_2
  import sort_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter bit UNSIGNED_CMP = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic              b_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              order_err
);

  merge_state_t      r_state;
  logic              w_load;
  logic              w_a_le_b;
  logic              w_a_fire;
  logic              w_b_fire;
  logic              w_push;
  logic              w_last;
  logic [DATA_W-1:0] w_data;

  assign w_a_le_b = le(a_data, b_data, UNSIGNED_CMP);

  // Readies are derived from the current state and the compare; in MERGE
  // nothing moves until both heads are visible, otherwise ordering is lost.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    w_last  = 1'b0;
    if (!rst && w_load) begin
      case (r_state)
        MERGE: begin
          if (a_valid && b_valid) begin
            a_ready = w_a_le_b;
            b_ready = !w_a_le_b;
          end
        end
        DRAIN_A: begin
          a_ready = 1'b1;
          w_last  = a_last;
        end
        DRAIN_B: begin
          b_ready = 1'b1;
          w_last  = b_last;
        end
        default: ;
      endcase
    end
  end

  assign w_a_fire = a_valid && a_ready;
  assign w_b_fire = b_valid && b_ready;
  assign w_push   = w_a_fire || w_b_fire;
  assign w_data   = w_a_fire ? a_data : b_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MERGE;
    end else begin
      case (r_state)
        MERGE: begin
          // The stream whose run ended is done; the other one drains.
          if (w_a_fire && a_last) begin
            r_state <= DRAIN_B;
          end else if (w_b_fire && b_last) begin
            r_state <= DRAIN_A;
          end
        end
        DRAIN_A: if (w_a_fire && a_last) r_state <= MERGE;
        DRAIN_B: if (w_b_fire && b_last) r_state <= MERGE;
        default: r_state <= MERGE;
      endcase
    end
  end

  stream_out_reg #(
    .DATA_W (DATA_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_data      (w_data),
    .i_last      (w_last),
    .i_out_ready (out_ready),
    .o_load      (w_load),
    .o_valid     (out_valid),
    .o_data      (out_data),
    .o_last      (out_last)
  );

`ifdef MERGE_STREAM_ORDER_CHECK_EN
  logic [DATA_W-1:0] r_prev;
  logic              r_prev_ok;
  logic              r_order_err;

  // r_prev_ok is clear for the first beat of every run, so run boundaries
  // never count as a descent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_prev_ok   <= 1'b0;
      r_order_err <= 1'b0;
    end else if (out_valid && out_ready) begin
      if (r_prev_ok && !le(r_prev, out_data, UNSIGNED_CMP)) begin
        r_order_err <= 1'b1;
      end
      r_prev    <= out_data;
      r_prev_ok <= !out_last;
    end
  end

  assign order_err = r_order_err;
`else
  assign order_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_merge_stream_2.sv
`default_nettype none
// ============================================================================
// Module      : tb_merge_stream_2
// Description : Self-checking bench for merge_stream_2: cycle-exact vector
//               table for the basic merge, plus stream-level sequences for
//               ties, backpressure, single-element runs, reset and ordering.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_merge_stream_2;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, a_ready, a_last;
  logic        b_valid, b_ready, b_last;
  logic [31:0] a_data, b_data;
  logic        out_valid, out_ready, out_last, order_err;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  merge_stream_2 #(
    .DATA_W       (32),
    .UNSIGNED_CMP (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .a_last    (a_last),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .b_last    (b_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .order_err (order_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        av;
    logic [31:0] ad;
    logic        al;
    logic        bv;
    logic [31:0] bd;
    logic        bl;
    logic        ordy;
    logic        ear;
    logic        ebr;
    logic        eov;
    logic [31:0] eod;
    logic        eol;
  } vec_t;

  vec_t tv[7];

  logic [31:0] qa[$], qb[$], qexp[$];
  bit          qrdy[$], qsrc[$];

  task automatic idle();
    a_valid = 1'b0; a_data = '0; a_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic apply(input vec_t v);
    a_valid = v.av; a_data = v.ad; a_last = v.al;
    b_valid = v.bv; b_data = v.bd; b_last = v.bl;
    out_ready = v.ordy;
  endtask

  // Drives qa/qb as two runs, qrdy as a repeating out_ready pattern, and
  // checks the merged stream against qexp/qsrc (0 = from A, 1 = from B).
  task automatic run(input string nm, input bit chk_err0);
    int ia = 0, ib = 0, nout = 0, cyc = 0;
    bit pend[$];
    logic held_v = 1'b0;
    logic [31:0] held_d = '0;
    while (nout < qexp.size() && cyc < 200) begin
      a_valid = (ia < qa.size());
      a_data  = a_valid ? qa[ia] : 32'd0;
      a_last  = a_valid && (ia == qa.size() - 1);
      b_valid = (ib < qb.size());
      b_data  = b_valid ? qb[ib] : 32'd0;
      b_last  = b_valid && (ib == qb.size() - 1);
      out_ready = qrdy[cyc % qrdy.size()];
      #1;
      if (held_v) begin
        chk({nm, " stall_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, " stall_data"}, out_data, held_d);
      end
      chk({nm, " one_ready"}, {31'd0, a_ready & b_ready}, 32'd0);
      if (out_valid && out_ready) begin
        chk({nm, " data"}, out_data, qexp[nout]);
        chk({nm, " last"}, {31'd0, out_last}, {31'd0, nout == qexp.size() - 1});
        chk({nm, " pending"}, pend.size(), 32'd1);
        if (pend.size() > 0) chk({nm, " source"}, {31'd0, pend.pop_front()}, {31'd0, qsrc[nout]});
        nout++;
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (a_valid && a_ready) begin pend.push_back(1'b0); ia++; end
      if (b_valid && b_ready) begin pend.push_back(1'b1); ib++; end
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " beats_out"}, nout, qexp.size());
    chk({nm, " a_consumed"}, ia, qa.size());
    chk({nm, " b_consumed"}, ib, qb.size());
    idle();
    #1;
    chk({nm, " drained"}, {31'd0, out_valid}, 32'd0);
    if (chk_err0) chk({nm, " order_err"}, {31'd0, order_err}, 32'd0);
  endtask

  initial begin
    // A=[1,4,9] B=[2,3,10], out_ready=1: cycle-exact expectations.
    tv[0] = '{1'b1, 32'd1, 1'b0, 1'b1, 32'd2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'd1,  1'b0};
    tv[1] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd2,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd2,  1'b0};
    tv[2] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd3,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd3,  1'b0};
    tv[3] = '{1'b1, 32'd4, 1'b0, 1'b1, 32'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd4,  1'b0};
    tv[4] = '{1'b1, 32'd9, 1'b1, 1'b1, 32'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'd9,  1'b0};
    tv[5] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'd10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'd10, 1'b1};
    tv[6] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0};

    // Reset with both streams offering data: nothing may be accepted.
    rst = 1'b1;
    apply(tv[0]);
    @(posedge clk); @(posedge clk); #1;
    chk("rst a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst out_last", {31'd0, out_last}, 32'd0);
    chk("rst order_err", {31'd0, order_err}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      apply(tv[i]);
      #1;
      chk($sformatf("vec%0d a_ready", i), {31'd0, a_ready}, {31'd0, tv[i].ear});
      chk($sformatf("vec%0d b_ready", i), {31'd0, b_ready}, {31'd0, tv[i].ebr});
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].eov});
      if (tv[i].eov) begin
        chk($sformatf("vec%0d out_data", i), out_data, tv[i].eod);
        chk($sformatf("vec%0d out_last", i), {31'd0, out_last}, {31'd0, tv[i].eol});
      end
    end
    idle();

    qa = {32'd5, 32'd5}; qb = {32'd5}; qrdy = {1'b1};
    qexp = {32'd5, 32'd5, 32'd5}; qsrc = {1'b0, 1'b0, 1'b1};
    run("tie", 1'b1);

    qa = {32'd1, 32'd4, 32'd9}; qb = {32'd2, 32'd3, 32'd10};
    qrdy = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    qexp = {32'd1, 32'd2, 32'd3, 32'd4, 32'd9, 32'd10};
    qsrc = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    run("backpressure", 1'b1);

    qa = {32'd7}; qb = {32'd3}; qrdy = {1'b1};
    qexp = {32'd3, 32'd7}; qsrc = {1'b1, 1'b0};
    run("single", 1'b1);
    qa = {32'd0}; qb = {32'd0};
    qexp = {32'd0, 32'd0}; qsrc = {1'b0, 1'b1};
    run("single_zero", 1'b1);

    // Unsigned compare: the top-bit-set value must sort above 1.
    qa = {32'h8000_0000}; qb = {32'd1};
    qexp = {32'd1, 32'h8000_0000}; qsrc = {1'b1, 1'b0};
    run("unsigned", 1'b1);

    // Reset two beats into a run; the partial run is discarded.
    apply(tv[0]); @(posedge clk); #1;
    apply(tv[1]); @(posedge clk); #1;
    rst = 1'b1;
    apply(tv[2]);
    #1;
    chk("midrst a_ready", {31'd0, a_ready}, 32'd0);
    chk("midrst b_ready", {31'd0, b_ready}, 32'd0);
    @(posedge clk); #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;
    idle();
    qa = {32'd8}; qb = {32'd6}; qrdy = {1'b1};
    qexp = {32'd6, 32'd8}; qsrc = {1'b1, 1'b0};
    run("after_rst", 1'b1);

    // Unsorted input run: passes through as merged; the checker flags it.
    qa = {32'd9, 32'd1}; qb = {32'd20}; qrdy = {1'b1};
    qexp = {32'd9, 32'd1, 32'd20}; qsrc = {1'b0, 1'b0, 1'b1};
    run("unsorted", 1'b0);
    @(posedge clk); #1;
`ifdef MERGE_STREAM_ORDER_CHECK_EN
    chk("unsorted order_err", {31'd0, order_err}, 32'd1);
`else
    chk("unsorted order_err", {31'd0, order_err}, 32'd0);
`endif
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("order_err cleared", {31'd0, order_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
